cube_scramble_seq: RTL

CUBE_SCRAMBLE_SEQ -- requirements
Module: cube_scramble_seq

---
 rtl/cube_scramble_seq_pkg.sv | 32 +++
 rtl/cube_scramble_seq_if.sv | 23 ++
 rtl/cube_scramble_seq_lfsr16.sv | 23 ++
 rtl/cube_scramble_seq.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cube_scramble_seq_pkg.sv
// Shared constants and types for the cube scrambler: face/rotation codes,
// LFSR geometry and the sequencer state encoding.
package cube_pkg;

    localparam int unsigned       LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    localparam logic [2:0] FACE_U    = 3'd0;
    localparam logic [2:0] FACE_D    = 3'd1;
    localparam logic [2:0] FACE_F    = 3'd2;
    localparam logic [2:0] FACE_B    = 3'd3;
    localparam logic [2:0] FACE_L    = 3'd4;
    localparam logic [2:0] FACE_R    = 3'd5;
    localparam logic [2:0] FACE_NONE = 3'd7;

    localparam logic [1:0] ROT_CW  = 2'd1;
    localparam logic [1:0] ROT_DBL = 2'd2;
    localparam logic [1:0] ROT_CCW = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_OFFER,
        S_FIN
    } state_e;

    // Galois step: shift right, fold the tap mask in when a one falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/cube_scramble_seq_if.sv
// Move handshake between the scrambler (master) and its consumer (slave).
interface cube_scramble_seq_if;

    logic       move_valid;
    logic       move_ready;
    logic [2:0] move_face;
    logic [1:0] move_rot;

    modport master (
        output move_valid,
        output move_face,
        output move_rot,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_face,
        input  move_rot,
        output move_ready
    );

endinterface

// File: rtl/cube_scramble_seq_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero SEED is replaced by 1 so the
// register can never lock up in the all-zero state.
module cube_lfsr16
    import cube_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED_EFF;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/cube_scramble_seq.sv
// Random cube scramble generator: draws face/rotation moves from an LFSR and
// offers them one at a time. Define CUBE_SCRAMBLE_FACE_FILTER_EN to forbid
// consecutive moves on the same face.
module cube_scramble_seq
    import cube_pkg::*;
#(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MAX_LEN = 63
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [5:0]                 length,
    cube_scramble_seq_if.master        mv,
    output logic                       busy,
    output logic                       done,
    output logic [5:0]                 moves_issued
);

    localparam logic [5:0] LEN_CAP = (MAX_LEN > 63) ? 6'd63 : 6'(MAX_LEN);

    logic [LFSR_W-1:0] lfsr;
    state_e            state;
    logic [5:0]        len_q;
    logic [5:0]        len_clamped;
    logic [5:0]        next_cnt;
    logic [2:0]        cand_face;
    logic [1:0]        cand_rot;
    logic              cand_ok;
`ifdef CUBE_SCRAMBLE_FACE_FILTER_EN
    logic [2:0]        prev_face;
`endif

    cube_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign cand_face   = lfsr[2:0];
    assign cand_rot    = lfsr[4:3];
    assign len_clamped = (length > LEN_CAP) ? LEN_CAP : length;
    assign next_cnt    = moves_issued + 6'd1;

    always_comb begin
        cand_ok = (cand_face <= FACE_R) && (cand_rot != 2'd0);
`ifdef CUBE_SCRAMBLE_FACE_FILTER_EN
        cand_ok = cand_ok && (cand_face != prev_face);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            mv.move_valid <= 1'b0;
            mv.move_face  <= '0;
            mv.move_rot   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            moves_issued  <= '0;
            len_q         <= '0;
`ifdef CUBE_SCRAMBLE_FACE_FILTER_EN
            prev_face     <= FACE_NONE;
`endif
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                // A move accepted in the abort cycle still counts.
                if (state == S_OFFER && mv.move_ready) begin
                    moves_issued <= next_cnt;
                end
                state         <= S_IDLE;
                busy          <= 1'b0;
                mv.move_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            moves_issued <= '0;
                            len_q        <= len_clamped;
                            busy         <= 1'b1;
`ifdef CUBE_SCRAMBLE_FACE_FILTER_EN
                            prev_face    <= FACE_NONE;
`endif
                            if (len_clamped != '0) begin
                                state <= S_GEN;
                            end else begin
                                state <= S_FIN;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_GEN: begin
                        if (cand_ok) begin
                            mv.move_face  <= cand_face;
                            mv.move_rot   <= cand_rot;
                            mv.move_valid <= 1'b1;
                            state         <= S_OFFER;
                        end
                    end
                    S_OFFER: begin
                        if (mv.move_ready) begin
                            mv.move_valid <= 1'b0;
                            moves_issued  <= next_cnt;
`ifdef CUBE_SCRAMBLE_FACE_FILTER_EN
                            prev_face     <= mv.move_face;
`endif
                            if (next_cnt == len_q) begin
                                state <= S_FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= S_GEN;
                            end
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
